// File: rtl/rggen_bit_field_counter.sv
// rtl/rggen_bit_field_counter.sv - counter-type register bit field with hw up/down stepping
//
// Purpose:
//   A software-visible counter field. Hardware events step it up or down by a
//   variable amount. It can saturate or wrap. Overflow and underflow are kept
//   as sticky flags. An optional read-clear mode loses no events, and a
//   threshold compare is provided.
//
// Ports:
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_sw_valid            software access strobe
//   i_sw_read_mask        non-zero marks a read of this field
//   i_sw_write_enable     write qualifier (active level = SW_WRITE_ENABLE_POLARITY)
//   i_sw_write_mask       per-bit write mask
//   i_sw_write_data       write data
//   o_sw_read_data        counter value before this cycle's update
//   i_hw_up/_step         increment request and amount
//   i_hw_down/_step       decrement request and amount
//   i_hw_clear            synchronous clear (drops hw steps of that cycle)
//   i_flag_clear          clears the sticky flags
//   i_threshold           compare value
//   o_value               registered counter value
//   o_overflow            sticky overflow flag
//   o_underflow           sticky underflow flag
//   o_threshold_hit       o_value >= i_threshold (unsigned)
module rggen_bit_field_counter #(
  parameter int               WIDTH                    = 8,
  parameter logic [WIDTH-1:0] INITIAL_VALUE            = '0,
  parameter int               STEP_WIDTH               = 1,
  parameter int               WRAP                     = 0,
  parameter int               READ_CLEAR               = 0,
  parameter logic             SW_WRITE_ENABLE_POLARITY = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_sw_valid,
  input  logic [WIDTH-1:0]      i_sw_read_mask,
  input  logic                  i_sw_write_enable,
  input  logic [WIDTH-1:0]      i_sw_write_mask,
  input  logic [WIDTH-1:0]      i_sw_write_data,
  output logic [WIDTH-1:0]      o_sw_read_data,
  input  logic                  i_hw_up,
  input  logic [STEP_WIDTH-1:0] i_hw_up_step,
  input  logic                  i_hw_down,
  input  logic [STEP_WIDTH-1:0] i_hw_down_step,
  input  logic                  i_hw_clear,
  input  logic                  i_flag_clear,
  input  logic [WIDTH-1:0]      i_threshold,
  output logic [WIDTH-1:0]      o_value,
  output logic                  o_overflow,
  output logic                  o_underflow,
  output logic                  o_threshold_hit
);

  // Two guard bits: one for carry above 2^WIDTH-1, one as the sign bit.
  localparam int SUM_W = WIDTH + 2;

  logic [WIDTH-1:0] r_value;
  logic             r_overflow;
  logic             r_underflow;

  logic             w_sw_read;
  logic             w_sw_write;
  logic             w_discard_steps;
  logic [WIDTH-1:0] w_base;
  logic [SUM_W-1:0] w_up;
  logic [SUM_W-1:0] w_down;
  logic [SUM_W-1:0] w_net;
  logic [SUM_W-1:0] w_sum;
  logic             w_overflow;
  logic             w_underflow;
  logic [WIDTH-1:0] w_next;

  assign w_sw_read  = i_sw_valid && (i_sw_read_mask != '0);
  assign w_sw_write = i_sw_valid && (i_sw_write_mask != '0) &&
                      (i_sw_write_enable == SW_WRITE_ENABLE_POLARITY);

  // Base value priority: hw clear, then sw write, then read-clear.
  // Read-clear keeps the hw steps so events arriving with the read survive.
  always_comb begin
    w_base          = r_value;
    w_discard_steps = 1'b0;
    if (i_hw_clear) begin
      w_base          = '0;
      w_discard_steps = 1'b1;
    end else if (w_sw_write) begin
      w_base          = (r_value & ~i_sw_write_mask) |
                        (i_sw_write_data & i_sw_write_mask);
      w_discard_steps = 1'b1;
    end else if (w_sw_read && (READ_CLEAR != 0)) begin
      w_base = '0;
    end
  end

  // Two's-complement arithmetic in SUM_W bits. The steps are zero-extended,
  // so simultaneous up and down cancel.
  assign w_up   = (i_hw_up   && !w_discard_steps) ? SUM_W'(i_hw_up_step)   : '0;
  assign w_down = (i_hw_down && !w_discard_steps) ? SUM_W'(i_hw_down_step) : '0;
  assign w_net  = w_up - w_down;
  assign w_sum  = {2'b00, w_base} + w_net;

  // The step is never wider than the counter, so the sum stays in
  // [-(2^WIDTH-1), 2^(WIDTH+1)-2].
  assign w_underflow = w_sum[SUM_W-1];
  assign w_overflow  = !w_sum[SUM_W-1] && w_sum[WIDTH];

  always_comb begin
    w_next = w_sum[WIDTH-1:0];
    if (w_overflow && (WRAP == 0)) begin
      w_next = '1;
    end else if (w_underflow && (WRAP == 0)) begin
      w_next = '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_value     <= INITIAL_VALUE;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_value <= w_next;
      // A new event wins over a flag clear in the same cycle.
      if (w_overflow) begin
        r_overflow <= 1'b1;
      end else if (i_flag_clear) begin
        r_overflow <= 1'b0;
      end
      if (w_underflow) begin
        r_underflow <= 1'b1;
      end else if (i_flag_clear) begin
        r_underflow <= 1'b0;
      end
    end
  end

  assign o_sw_read_data  = r_value;
  assign o_value         = r_value;
  assign o_overflow      = r_overflow;
  assign o_underflow     = r_underflow;
  assign o_threshold_hit = (r_value >= i_threshold);

endmodule
